// File: rtl/fir_decim_fifo_if.sv
// Valid/ready sample stream from the decimating FIFO toward its consumer.
interface fir_decim_fifo_if #(
    parameter int unsigned DATA_WIDTH = 16
) ();
    logic signed [DATA_WIDTH-1:0] data;
    logic                         valid;
    logic                         ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/fir_decim_fifo.sv
// FIR output post-processing: discard the start-up transient, keep every DECIM-th sample,
// and buffer kept samples in a first-word-fall-through FIFO driving a valid/ready stream.
module fir_decim_fifo #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned DECIM         = 4,
    parameter int unsigned PRIME_SAMPLES = 24,
    parameter int unsigned FIFO_DEPTH    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic signed [DATA_WIDTH-1:0]  fir_in,
    input  logic                          phase_clr,
    fir_decim_fifo_if.master              m,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          primed,
    output logic                          overflow
);

    localparam int unsigned AddrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW   = AddrW + 1;
    localparam int unsigned PhaseW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned PrimeW = (PRIME_SAMPLES > 1) ? $clog2(PRIME_SAMPLES) : 1;

    localparam logic [PrimeW-1:0] PrimeLast =
        PrimeW'((PRIME_SAMPLES > 0) ? PRIME_SAMPLES - 1 : 0);
    localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(DECIM - 1);
    localparam logic [CntW-1:0]   CntFull   = CntW'(FIFO_DEPTH);

    // Priming state
    logic [PrimeW-1:0] prime_cnt_q, prime_cnt_d;
    logic              primed_q, primed_d;

    // Decimation state
    logic [PhaseW-1:0] phase_q, phase_d;
    logic [PhaseW-1:0] phase_base;
    logic              keep;

    // FIFO state
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AddrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  full;
    logic                  push;
    logic                  pop;

    // ------------------------------------------------------------------------
    // Priming: the strobe that completes the count is itself discarded.
    // ------------------------------------------------------------------------
    always_comb begin
        prime_cnt_d = prime_cnt_q;
        primed_d    = primed_q;
        if (!primed_q) begin
            if (PRIME_SAMPLES == 0) begin
                primed_d = 1'b1;
            end else if (enable) begin
                if (prime_cnt_q == PrimeLast) begin
                    primed_d = 1'b1;
                end else begin
                    prime_cnt_d = prime_cnt_q + PrimeW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Decimation: a phase_clr coinciding with a strobe makes that strobe phase 0.
    // ------------------------------------------------------------------------
    always_comb begin
        phase_d    = phase_q;
        phase_base = phase_q;
        keep       = 1'b0;
        if (primed_q) begin
            if (enable) begin
                phase_base = phase_clr ? '0 : phase_q;
                keep       = (phase_base == '0);
                phase_d    = (phase_base == PhaseLast) ? '0 : phase_base + PhaseW'(1);
            end else if (phase_clr) begin
                phase_d = '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FIFO control: a pop frees the slot so a push into a full FIFO still succeeds.
    // ------------------------------------------------------------------------
    always_comb begin
        pop        = (count_q != '0) && m.ready;
        full       = (count_q == CntFull);
        push       = keep && (!full || pop);
        overflow_d = overflow_q | (keep && full && !pop);

        wr_ptr_d = push ? wr_ptr_q + AddrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AddrW'(1) : rd_ptr_q;

        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prime_cnt_q <= '0;
            primed_q    <= 1'b0;
            phase_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            prime_cnt_q <= prime_cnt_d;
            primed_q    <= primed_d;
            phase_q     <= phase_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage needs no reset: output is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= fir_in;
        end
    end

    assign m.valid    = (count_q != '0);
    assign m.data     = (count_q != '0) ? mem[rd_ptr_q] : '0;
    assign fill_level = count_q;
    assign primed     = primed_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Randomised and directed bench for fir_decim_fifo, checked against a queue-based model.
module tb_fir_decim_fifo;

    localparam int unsigned DW    = 16;
    localparam int unsigned DECIM = 4;
    localparam int unsigned PRIME = 24;
    localparam int unsigned DEPTH = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic signed [DW-1:0] fir_in;
    logic                 phase_clr;
    logic                 ready;
    logic [3:0]           fill_level;
    logic                 primed;
    logic                 overflow;

    fir_decim_fifo_if #(.DATA_WIDTH(DW)) s_if ();
    assign s_if.ready = ready;

    fir_decim_fifo #(
        .DATA_WIDTH    (DW),
        .DECIM         (DECIM),
        .PRIME_SAMPLES (PRIME),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fir_in     (fir_in),
        .phase_clr  (phase_clr),
        .m          (s_if.master),
        .fill_level (fill_level),
        .primed     (primed),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic signed [DW-1:0] exp_q[$];
    int                   m_fill    = 0;
    int                   m_nstrobe = 0;
    int                   m_k       = 0;
    bit                   m_ovf     = 1'b0;
    bit                   mon_on    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: strobes are counted from reset; after priming, the position since the last
    // phase resync decides which samples are kept.
    always @(posedge clk) begin : model
        bit pop;
        bit kept;
        if (rst) begin
            m_fill    = 0;
            m_nstrobe = 0;
            m_k       = 0;
            m_ovf     = 1'b0;
            exp_q.delete();
        end else begin
            pop  = (m_fill != 0) && ready;
            kept = 1'b0;
            if (m_nstrobe < PRIME) begin
                if (enable) m_nstrobe++;
            end else if (phase_clr) begin
                if (enable) begin
                    kept = 1'b1;
                    m_k  = 1;
                end else begin
                    m_k = 0;
                end
            end else if (enable) begin
                kept = ((m_k % DECIM) == 0);
                m_k++;
            end
            if (kept) begin
                if (m_fill < DEPTH || pop) begin
                    exp_q.push_back(fir_in);
                    m_fill++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (pop) m_fill--;
        end
    end

    // Monitor: compares outputs mid-cycle and retires the head on each handshake.
    always @(negedge clk) begin
        if (mon_on) begin
            check("fill_level", 32'(fill_level), 32'(m_fill));
            check("m_valid", 32'(s_if.valid), 32'(m_fill != 0));
            check("primed", 32'(primed), 32'(m_nstrobe >= PRIME));
            check("overflow", 32'(overflow), 32'(m_ovf));
            if (m_fill != 0 && exp_q.size() > 0) begin
                check("m_data", 32'(s_if.data), 32'(exp_q[0]));
                if (ready) void'(exp_q.pop_front());
            end else begin
                check("m_data_idle", 32'(s_if.data), 32'd0);
            end
        end
    end

    task automatic step(input logic en, input logic [DW-1:0] din, input logic clr,
                        input logic rdy);
        enable    = en;
        fir_in    = din;
        phase_clr = clr;
        ready     = rdy;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, '0, 1'b0, 1'b1);
        rst = 1'b0;
    endtask

    initial begin
        int thr;
        rst       = 1'b1;
        enable    = 1'b0;
        fir_in    = '0;
        phase_clr = 1'b0;
        ready     = 1'b1;
        do_reset();
        mon_on = 1'b1;

        // Continuous strobing, consumer always ready
        do_reset();
        for (int k = 0; k < 60; k++) begin
            step(1'b1, DW'(k), 1'b0, 1'b1);
            if (k == 23) begin
                check("t1_primed", 32'(primed), 32'd1);
                check("t1_no_valid", 32'(s_if.valid), 32'd0);
            end
            if (k == 24) check("t1_first", 32'(s_if.data), 32'd24);
        end

        // Stalled consumer: fill, overflow, then drain
        do_reset();
        for (int k = 0; k < 70; k++) step(1'b1, DW'(k), 1'b0, 1'b0);
        check("t2_full", 32'(fill_level), 32'd8);
        check("t2_ovf", 32'(overflow), 32'd1);
        check("t2_head", 32'(s_if.data), 32'd24);
        repeat (12) step(1'b0, '0, 1'b0, 1'b1);
        check("t2_drained", 32'(fill_level), 32'd0);
        check("t2_ovf_sticky", 32'(overflow), 32'd1);

        // Full FIFO, pop only on kept-sample cycles
        do_reset();
        for (int k = 0; k < 100; k++)
            step(1'b1, DW'(k), 1'b0, (k >= 56) && (k % 4 == 0));
        check("t3_full", 32'(fill_level), 32'd8);
        check("t3_no_ovf", 32'(overflow), 32'd0);

        // Phase resync with and without a strobe
        do_reset();
        for (int k = 0; k < 40; k++) step(1'b1, DW'(k), k == 30, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b1, DW'(77), 1'b0, 1'b1);
        check("t4_resync", 32'(s_if.data), 32'd77);

        // Sparse strobes
        do_reset();
        for (int c = 0; c < 300; c++) begin
            if (c % 3 == 0) step(1'b1, DW'(c / 3), 1'b0, 1'b1);
            else            step(1'b0, DW'($urandom), 1'b0, 1'b1);
        end

        // Reset with a partly filled FIFO
        do_reset();
        for (int k = 0; k < 41; k++) step(1'b1, DW'(k), 1'b0, 1'b0);
        check("t6_fill5", 32'(fill_level), 32'd5);
        rst = 1'b1;
        step(1'b1, DW'(99), 1'b0, 1'b0);
        rst = 1'b0;
        check("t6_rst_fill", 32'(fill_level), 32'd0);
        check("t6_rst_valid", 32'(s_if.valid), 32'd0);
        check("t6_rst_data", 32'(s_if.data), 32'd0);
        check("t6_rst_primed", 32'(primed), 32'd0);
        check("t6_rst_ovf", 32'(overflow), 32'd0);
        for (int k = 0; k < 24; k++) step(1'b1, DW'(1000 + k), 1'b0, 1'b1);
        check("t6_reprime_empty", 32'(s_if.valid), 32'd0);
        check("t6_reprimed", 32'(primed), 32'd1);
        step(1'b1, DW'(500), 1'b0, 1'b1);
        check("t6_first", 32'(s_if.data), 32'd500);

        // Random traffic with varying consumer throughput
        thr = 6;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) thr = int'($urandom_range(0, 8));
            rst = ($urandom % 400) == 0;
            step(($urandom % 3) != 0, DW'($urandom), ($urandom % 16) == 0,
                 ($urandom % 8) < thr);
        end
        rst = 1'b0;
        step(1'b0, '0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_decim_fifo.md
Name: fir_decim_fifo

Overview:
Downstream stage of the symmetric 16-tap FIR filter. It takes the filter's Q1.15 output on every sample strobe and discards the start-up transient (priming). It then keeps every DECIM-th sample and buffers the kept samples in a small first-word-fall-through FIFO, which drives a valid/ready stream toward the consumer. Overflow is flagged, never silently hidden.

Parameters:
DATA_WIDTH, 16, sample width (Q1.15)
DECIM, 4, decimation ratio; must be >= 1; 1 = keep every sample
PRIME_SAMPLES, 24, number of initial strobed samples discarded after reset; 0 = no priming
FIFO_DEPTH, 8, FIFO entries; must be a power of 2 and >= 2

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
enable  in  1  sample strobe, the same strobe that drives the filter; one sample per high cycle
fir_in  in  DATA_WIDTH  signed filter output, sampled only on enable cycles
phase_clr  in  1  resynchronises the decimation phase to 0
m_data  out  DATA_WIDTH  signed head-of-FIFO sample
m_valid  out  1  FIFO non-empty
m_ready  in  1  consumer accepts m_data when m_valid && m_ready
fill_level  out  $clog2(FIFO_DEPTH)+1  number of entries currently stored
primed  out  1  priming complete
overflow  out  1  sticky; a kept sample was dropped because the FIFO was full

Behaviour:
- Reset (rst=1 at a clock edge):
  - FIFO emptied; m_valid=0, m_data=0, fill_level=0.
  - primed=0, overflow=0.
  - Prime counter and phase counter cleared.
  - Reset during operation behaves identically: the FIFO is flushed and priming restarts.
- Priming:
  - The prime counter increments on each enable cycle while primed=0.
  - Samples seen during priming are discarded.
  - primed registers to 1 on the edge that consumes the PRIME_SAMPLES-th strobe; that strobe's sample is itself discarded.
  - primed stays 1 until rst.
  - With PRIME_SAMPLES=0, primed=1 on the first cycle after reset.
- Decimation (only while primed=1):
  - Phase counter runs 0..DECIM-1, advances on each enable and wraps to 0.
  - A sample is kept when its enable cycle has phase==0.
  - phase_clr without enable: phase <= 0.
  - phase_clr with enable on the same cycle: the sample is kept (treated as phase 0) and phase <= 1, or 0 if DECIM=1.
  - phase_clr during priming has no effect.
  - Cycles with enable=0 change nothing except the pop side.
- FIFO push/pop:
  - A kept sample is pushed on its enable edge.
  - It is visible as m_data with m_valid=1 on the next cycle (latency 1 from the strobe).
  - Pop happens when m_valid && m_ready at an edge.
  - Push and pop in the same cycle: fill_level unchanged; order preserved.
  - Full and push with no pop: the new sample is dropped, FIFO contents are unchanged, overflow <= 1.
  - Full and push with pop: both succeed and no overflow is raised.
  - Empty with m_ready=1: no effect; fill_level never underflows.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Output rules:
  - m_valid = (fill_level != 0).
  - m_data = head entry when m_valid=1, else 0.
  - m_data and m_valid hold stable while m_valid && !m_ready.
  - fill_level, m_valid and m_data are derived from registered state only; no combinational path from m_ready or enable to any output.
- Arithmetic: samples pass through bit-exact; no scaling, rounding or saturation.

Test Plan:
1. Defaults, enable every cycle, fir_in = k on strobe k (k=0,1,2,...), m_ready=1 -> primed rises after strobe 23; m_data sequence is 24, 28, 32, 36...; each value appears one cycle after its strobe; overflow=0.
2. Same stimulus with m_ready=0 -> samples 24..52 stored, fill_level=8; sample 56 dropped and overflow=1. Then m_ready=1 -> drains 24, 28, ..., 52 in order and fill_level returns to 0; overflow stays 1.
3. FIFO full, continuous strobing, m_ready=1 on exactly the kept-sample cycle -> fill_level stays 8, overflow stays 0, output order intact.
4. phase_clr pulsed together with strobe 30 -> kept samples are 24, 28, 30, 34, 38; phase_clr pulsed on a non-enable cycle -> the next strobe is kept.
5. enable high one cycle in three, fir_in = k -> same kept values as test 1 (24, 28, ...); outputs unchanged on non-strobe cycles.
6. rst asserted with fill_level=5 -> next cycle fill_level=0, m_valid=0, m_data=0, primed=0, overflow=0; the next 24 strobes are discarded before any output.
